// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises RXD, samples each bit at its midpoint and
// reports good bytes with DATA_READY and bad stop bits with FRAME_ERR.
module uart_recv #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] DATA,
    output logic       DATA_READY,
    output logic       FRAME_ERR,
    output logic       BUSY
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(10 * CLKS_PER_BIT);

    typedef enum logic [2:0] {
        WAIT_HIGH,
        IDLE,
        START,
        DATA_BITS,
        STOP
    } state_t;

    state_t           state;
    logic             sync1;
    logic             rx_s;
    logic [1:0]       primed;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sample_at;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // NOTE: synchronous reset -- RST is only acted on at a CLK edge, so it is
    // tested inside the clocked block rather than listed in the sensitivity list.
    // The synchroniser resets to the idle-high line level.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= RXD;
            rx_s  <= sync1;
        end
    end

    // primed marks that rx_s reflects the pin rather than the reset value,
    // so a line held low across reset is not mistaken for idle-high.
    // NOTE: non-blocking assignments keep every register updating from the
    // values of the previous cycle, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= WAIT_HIGH;
            primed     <= 2'b00;
            cnt        <= '0;
            sample_at  <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'h00;
            DATA       <= 8'h00;
            DATA_READY <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            DATA_READY <= 1'b0;
            FRAME_ERR  <= 1'b0;
            primed     <= {primed[0], 1'b1};

            case (state)
                WAIT_HIGH: begin
                    if (primed[1] && rx_s)
                        state <= IDLE;
                end

                IDLE: begin
                    // cnt tracks t, where t=0 is the cycle the low is seen
                    cnt       <= CNT_W'(1);
                    sample_at <= CNT_W'(HALF_BIT);
                    if (!rx_s)
                        state <= START;
                end

                START: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == sample_at) begin
                        sample_at <= sample_at + CNT_W'(CLKS_PER_BIT);
                        bit_idx   <= 3'd0;
                        state     <= rx_s ? IDLE : DATA_BITS;
                    end
                end

                DATA_BITS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == sample_at) begin
                        sample_at <= sample_at + CNT_W'(CLKS_PER_BIT);
                        shift     <= {rx_s, shift[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7)
                            state <= STOP;
                    end
                end

                STOP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == sample_at) begin
                        if (rx_s) begin
                            DATA       <= shift;
                            DATA_READY <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end
                end

                default: state <= WAIT_HIGH;
            endcase
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv at CLKS_PER_BIT=16: a scoreboard of
// expected bytes is filled by the serial driver and drained by a pulse monitor.
module tb_uart_recv;

    localparam int CPB = 16;
    // pin edge to DATA_READY: HALF_BIT + 9*CPB + 1, plus 2 synchroniser cycles
    localparam int LAT = CPB / 2 + 9 * CPB + 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RXD;
    logic [7:0] DATA;
    logic       DATA_READY;
    logic       FRAME_ERR;
    logic       BUSY;

    typedef struct {
        logic [7:0] data;
        int         due;
        bit         timed;
    } exp_t;

    exp_t sb[$];
    exp_t head;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   fe_count     = 0;
    int   dr_count     = 0;

    uart_recv #(.CLKS_PER_BIT(CPB)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXD        (RXD),
        .DATA       (DATA),
        .DATA_READY (DATA_READY),
        .FRAME_ERR  (FRAME_ERR),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish within 1000000 time units");
        $fatal(1, "timeout");
    end

    // Pulse monitor: every DATA_READY pops one expected byte.
    always @(posedge CLK) begin
        cyc++;
        #1;
        if (DATA_READY && FRAME_ERR) begin
            tests_run++;
            tests_failed++;
            $display("FAIL pulse_overlap: DATA_READY=1 FRAME_ERR=1 at cycle %0d, required never both", cyc);
        end
        if (FRAME_ERR) fe_count++;
        if (DATA_READY) begin
            dr_count++;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_byte: got DATA_READY with DATA=%02h at cycle %0d, required no pulse", DATA, cyc);
            end else begin
                head = sb.pop_front();
                if (DATA !== head.data) begin
                    tests_failed++;
                    $display("FAIL byte_value: got %02h, required %02h", DATA, head.data);
                end
                if (head.timed) begin
                    tests_run++;
                    if (cyc != head.due) begin
                        tests_failed++;
                        $display("FAIL byte_latency: pulse at cycle %0d, required cycle %0d", cyc, head.due);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input int period, input logic stop,
                             input bit expect_ok, input bit timed);
        exp_t e;
        if (expect_ok) begin
            e.data  = b;
            e.due   = cyc + LAT;
            e.timed = timed;
            sb.push_back(e);
        end
        RXD = 1'b0;
        repeat (period) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (period) @(negedge CLK);
        end
        RXD = stop;
        repeat (period) @(negedge CLK);
    endtask

    task automatic expect_drained(input string name);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_missing: %0d bytes not received, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        tests_run++;
        if (DATA !== 8'h00 || DATA_READY !== 1'b0 || FRAME_ERR !== 1'b0 || BUSY !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: DATA=%02h DR=%b FE=%b BUSY=%b, required 00 0 0 1",
                     DATA, DATA_READY, FRAME_ERR, BUSY);
        end
        RST = 1'b0;
        idle(5);
        tests_run++;
        if (BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: BUSY=%b after release on idle line, required 0", BUSY);
        end
    endtask

    task automatic test_single;
        int fe0 = fe_count;
        send_byte(8'h55, CPB, 1'b1, 1'b1, 1'b1);
        idle(20);
        expect_drained("single");
        tests_run++;
        if (DATA !== 8'h55 || fe_count != fe0) begin
            tests_failed++;
            $display("FAIL single_data: DATA=%02h frame_errs=%0d, required 55 and 0", DATA, fe_count - fe0);
        end
    endtask

    task automatic test_back_to_back;
        int dr0 = dr_count;
        send_byte(8'hA3, CPB, 1'b1, 1'b1, 1'b1);
        send_byte(8'h0F, CPB, 1'b1, 1'b1, 1'b1);
        idle(20);
        expect_drained("b2b");
        tests_run++;
        if (DATA !== 8'h0F || dr_count - dr0 != 2) begin
            tests_failed++;
            $display("FAIL b2b_data: DATA=%02h pulses=%0d, required 0F and 2", DATA, dr_count - dr0);
        end
    endtask

    task automatic test_glitch;
        int dr0 = dr_count;
        int fe0 = fe_count;
        bit saw_busy = 1'b0;
        RXD = 1'b0;
        idle(5);
        RXD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (BUSY) saw_busy = 1'b1;
        end
        tests_run++;
        if (!saw_busy || BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_busy: saw_busy=%b final BUSY=%b, required 1 and 0", saw_busy, BUSY);
        end
        tests_run++;
        if (dr_count != dr0 || fe_count != fe0) begin
            tests_failed++;
            $display("FAIL glitch_pulses: DR=%0d FE=%0d, required 0 and 0", dr_count - dr0, fe_count - fe0);
        end
        send_byte(8'h3C, CPB, 1'b1, 1'b1, 1'b1);
        idle(20);
        expect_drained("glitch");
    endtask

    task automatic test_frame_error;
        int dr0 = dr_count;
        int fe0 = fe_count;
        int busy_low = 0;
        send_byte(8'h81, CPB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (!BUSY) busy_low++;
        end
        tests_run++;
        if (fe_count - fe0 != 1) begin
            tests_failed++;
            $display("FAIL frame_err_count: got %0d FRAME_ERR pulses, required 1", fe_count - fe0);
        end
        tests_run++;
        if (DATA !== 8'h3C || dr_count != dr0 || busy_low != 0) begin
            tests_failed++;
            $display("FAIL frame_err_hold: DATA=%02h DR=%0d busy_low=%0d, required 3C 0 0",
                     DATA, dr_count - dr0, busy_low);
        end
        RXD = 1'b1;
        idle(10);
        send_byte(8'h7E, CPB, 1'b1, 1'b1, 1'b1);
        idle(20);
        expect_drained("after_break");
    endtask

    task automatic test_reset_mid_frame;
        int dr0 = dr_count;
        int fe0 = fe_count;
        fork
            send_byte(8'hFF, CPB, 1'b1, 1'b0, 1'b0);
            begin
                idle(60);
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
            end
        join
        idle(20);
        tests_run++;
        if (DATA !== 8'h00 || dr_count != dr0 || fe_count != fe0) begin
            tests_failed++;
            $display("FAIL midreset_discard: DATA=%02h DR=%0d FE=%0d, required 00 0 0",
                     DATA, dr_count - dr0, fe_count - fe0);
        end
        send_byte(8'h12, CPB, 1'b1, 1'b1, 1'b1);
        idle(20);
        expect_drained("midreset");
    endtask

    task automatic test_stuck_low;
        int dr0 = dr_count;
        int fe0 = fe_count;
        int busy_low = 0;
        int n = 0;
        RXD = 1'b0;
        RST = 1'b1;
        idle(3);
        RST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!BUSY) busy_low++;
        end
        tests_run++;
        if (busy_low != 0) begin
            tests_failed++;
            $display("FAIL stuck_busy: BUSY low for %0d cycles while line low, required 0", busy_low);
        end
        RXD = 1'b1;
        while (n < 10) begin
            @(posedge CLK);
            #1;
            n++;
            if (!BUSY) break;
        end
        tests_run++;
        if (n < 2 || n > 3) begin
            tests_failed++;
            $display("FAIL stuck_release: BUSY fell %0d cycles after release, required 2..3", n);
        end
        @(negedge CLK);
        idle(30);
        tests_run++;
        if (DATA !== 8'h00 || dr_count != dr0 || fe_count != fe0) begin
            tests_failed++;
            $display("FAIL stuck_no_byte: DATA=%02h DR=%0d FE=%0d, required 00 0 0",
                     DATA, dr_count - dr0, fe_count - fe0);
        end
    endtask

    task automatic test_baud_tolerance;
        int dr0 = dr_count;
        int fe0 = fe_count;
        send_byte(8'hC5, CPB + 1, 1'b1, 1'b1, 1'b0);
        idle(30);
        send_byte(8'hC5, CPB - 1, 1'b1, 1'b1, 1'b0);
        idle(30);
        expect_drained("baud");
        tests_run++;
        if (DATA !== 8'hC5 || dr_count - dr0 != 2 || fe_count != fe0) begin
            tests_failed++;
            $display("FAIL baud_data: DATA=%02h DR=%0d FE=%0d, required C5 2 0",
                     DATA, dr_count - dr0, fe_count - fe0);
        end
    endtask

    initial begin
        RST = 1'b1;
        RXD = 1'b1;
        idle(3);
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_error;
        test_reset_mid_frame;
        test_stuck_low;
        test_baud_tolerance;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
